msd_req_queue: RTL

//  Upstream request stage for the DIMM command controller. Accepts parsed CPU trace requests
//  (arrival time, core, op, address) and validates them. Holds each request until the cycle

---
 rtl/msd_req_queue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/msd_req_queue.sv
// Trace request stage: validates requests, holds each until its arrival time, then queues it in an in-order FWFT FIFO.
// Optional feature: define MSD_REQ_ORDER_CHECK_EN to drop requests whose time precedes the last legal accept.
module msd_req_queue #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 36,
    parameter int TIME_W    = 64,
    parameter int CORE_W    = 4,
    parameter int NUM_CORES = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TIME_W-1:0]          in_time,
    input  logic [CORE_W-1:0]          in_core,
    input  logic [1:0]                 in_op,
    input  logic [ADDR_W-1:0]          in_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_op,
    output logic [CORE_W-1:0]          out_core,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [TIME_W-1:0]          sim_time,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       q_full,
    output logic                       q_empty,
    output logic                       err_pulse,
    output logic [15:0]                err_count
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  FULL_CNT = DEPTH[CNT_W-1:0];
    localparam logic [CORE_W:0]   CORE_LIM = NUM_CORES[CORE_W:0];

    typedef enum logic [1:0] {ST_EMPTY, ST_WAIT_TIME, ST_WAIT_SPACE} stage_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [CORE_W-1:0] core;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    stage_t            state;
    logic [TIME_W-1:0] stage_time;
    entry_t            stage_ent;
    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic accept, illegal, order_bad, pop, room, push, time_hit;

`ifdef MSD_REQ_ORDER_CHECK_EN
    logic [TIME_W-1:0] last_time;
    assign order_bad = in_time < last_time;

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_time <= '0;
        else if (accept && !illegal)
            last_time <= in_time;
    end
`else
    assign order_bad = 1'b0;
`endif

    assign in_ready  = (state == ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign illegal   = (in_op == 2'd3) || ({1'b0, in_core} >= CORE_LIM) || in_addr[6] || order_bad;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign room      = !q_full || pop;
    assign time_hit  = sim_time >= stage_time;
    // WAIT_SPACE already saw its time gate pass, so only room matters there
    assign push      = room && ((state == ST_WAIT_SPACE) || (state == ST_WAIT_TIME && time_hit));

    assign q_count   = count;
    assign q_full    = (count == FULL_CNT);
    assign q_empty   = (count == '0);
    assign out_op    = mem[rd_ptr].op;
    assign out_core  = mem[rd_ptr].core;
    assign out_addr  = mem[rd_ptr].addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sim_time   <= '0;
            state      <= ST_EMPTY;
            stage_time <= '0;
            stage_ent  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
        end else begin
            sim_time  <= sim_time + 1'b1;
            err_pulse <= accept && illegal;
            if (accept && illegal && err_count != 16'hFFFF)
                err_count <= err_count + 1'b1;

            case (state)
                ST_EMPTY: begin
                    if (accept && !illegal) begin
                        state      <= ST_WAIT_TIME;
                        stage_time <= in_time;
                        stage_ent  <= '{op: in_op, core: in_core, addr: in_addr};
                    end
                end
                ST_WAIT_TIME: begin
                    if (push)
                        state <= ST_EMPTY;
                    else if (time_hit)
                        state <= ST_WAIT_SPACE;
                end
                ST_WAIT_SPACE: begin
                    if (push)
                        state <= ST_EMPTY;
                end
                default: state <= ST_EMPTY;
            endcase

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= stage_ent;
    end

endmodule
